// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch sequencer: holds the PC, fetches from
// instruction memory and hands each instruction to decode under valid/stall.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic        instr_valid_r;
    logic        misalign_err_r;
    logic [31:0] next_pc_s;

    // Redirect selection: register jump beats direct jump beats branch beats sequential.
    always_comb begin
        next_pc_s = pc_plus4;
        if (jr) begin
            next_pc_s = jr_target;
        end else if (jump) begin
            next_pc_s = jump_target;
        end else if (branch_taken) begin
            next_pc_s = branch_target;
        end else begin
            next_pc_s = pc_plus4;
        end
    end

    // Fetch sequencer state, PC and decode-side instruction register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= BOOT;
            pc_r           <= RESET_PC;
            instr_r        <= 32'h0000_0000;
            instr_valid_r  <= 1'b0;
            misalign_err_r <= 1'b0;
        end else begin
            case (state_r)
                BOOT: begin
                    state_r <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr_r       <= imem_rdata;
                        instr_valid_r <= 1'b1;
                        state_r       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        instr_valid_r <= 1'b0;
                        // A misaligned target freezes the core with pc left at the offender.
                        if (next_pc_s[1:0] != 2'b00) begin
                            misalign_err_r <= 1'b1;
                            state_r        <= HALT;
                        end else begin
                            pc_r    <= next_pc_s;
                            state_r <= FETCH;
                        end
                    end
                end
                HALT: begin
                    state_r <= HALT;
                end
                default: begin
                    state_r       <= HALT;
                    instr_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign pc           = pc_r;
    assign imem_addr    = pc_r;
    assign imem_req     = (state_r == FETCH);
    assign instr        = instr_r;
    assign instr_valid  = instr_valid_r;
    assign misalign_err = misalign_err_r;

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program counter register and instruction fetch sequencer for the 32-bit processor core. It holds the current PC and drives it to the PC+4 adder and to instruction memory. It takes back the incremented value and any branch/jump redirect, and presents each fetched instruction to decode under a valid/stall handshake. It sits directly upstream of the PC+4 adder and closes the loop through it.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high reset
- pc  output  32  current PC; feeds the PC+4 adder input
- pc_plus4  input  32  PC+4 adder output (the adder's somador_out)
- branch_taken  input  1  conditional branch resolved taken
- branch_target  input  32  branch target address
- jump  input  1  J/JAL redirect
- jump_target  input  32  jump target address
- jr  input  1  JR redirect (register target)
- jr_target  input  32  register target address
- stall  input  1  decode cannot accept the next instruction
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  fetch address; always equals pc
- imem_ack  input  1  memory returns data this cycle
- imem_rdata  input  32  fetched instruction word
- instr  output  32  registered instruction to decode
- instr_valid  output  1  instr holds a valid instruction
- misalign_err  output  1  sticky: a word-misaligned next PC was selected

## Operation
- States: BOOT, FETCH, ISSUE, HALT.
- Reset (asynchronous): pc=RESET_PC, state=BOOT, imem_req=0, instr=32'h0, instr_valid=0, misalign_err=0.
- BOOT: imem_req=0. Unconditionally goes to FETCH on the next edge.
- FETCH: imem_req=1 (combinational from state). If imem_ack=1: instr<=imem_rdata, instr_valid<=1, go to ISSUE. Otherwise stay, with pc and imem_addr held stable.
- ISSUE: imem_req=0, instr_valid=1.
  - stall=1: stay; pc, instr and instr_valid are held.
  - stall=0: pc<=next_pc, instr_valid<=0, go to FETCH.
- next_pc priority: jr ? jr_target : jump ? jump_target : branch_taken ? branch_target : pc_plus4.
- Redirect inputs are sampled only in ISSUE with stall=0. They are ignored in every other state and cycle.
- Misalignment check: if next_pc[1:0]!=2'b00 at the ISSUE/stall=0 edge:
  - pc is not updated.
  - misalign_err<=1, instr_valid<=0, go to HALT.
- HALT: imem_req=0, instr_valid=0, all state frozen. Only reset exits HALT.
- Arithmetic: this block performs no addition. Wrap-around is the adder's responsibility: pc=32'hFFFF_FFFC with pc_plus4=32'h0 loads 0 without error.
- imem_ack outside FETCH is ignored.

## Timing
- Minimum of 2 cycles per instruction: FETCH with same-cycle ack, then ISSUE.
- instr_valid rises on the edge that samples imem_ack=1 and stays high through every stalled ISSUE cycle.
- pc changes only on the edge leaving ISSUE. It is stable for the entire FETCH phase, including ack wait states.
- First fetch: imem_req goes high in the second cycle after reset deasserts (BOOT takes one cycle).
- Reset asserted mid-FETCH drops imem_req immediately; any in-flight ack is discarded. Reset asserted mid-ISSUE clears instr_valid immediately.
- Simultaneous redirects: priority order above; lower-priority targets are discarded.

## Test plan
- Sequential fetch: reset with RESET_PC=0, ack every FETCH cycle, no stall, pc_plus4 supplied by an adder model -> imem_addr sequence 0,4,8,C, one instr_valid pulse every 2 cycles.
- Wait states and stall: ack delayed 3 cycles at pc=8, then stall held 4 cycles in ISSUE -> imem_addr=8 held for 4 cycles; instr and instr_valid held through the stall; pc advances to C only after stall drops.
- Redirect priority: in ISSUE, assert jr=1 (0x100), jump=1 (0x200), branch_taken=1 (0x300) together -> pc=0x100. Repeat with jump and branch only -> pc=0x200.
- Ignored redirect: pulse branch_taken with target 0x40 during FETCH -> no effect; the next pc is pc_plus4.
- Misalignment: branch_target=0x102 taken in ISSUE -> misalign_err=1, pc unchanged, imem_req stays 0 for 10 cycles; reset clears to pc=RESET_PC.
- Wrap and async reset: pc=0xFFFF_FFFC, pc_plus4=0 -> pc=0, no error. Assert reset mid-FETCH between edges -> imem_req=0 in the same cycle, pc=RESET_PC.
